// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Instruction memory with a clear/load sequencer and a 1-cycle fetch
//            port. Define IMEM_PARITY_EN to add per-word even parity and
//            the parity_err output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
`ifdef IMEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state;
    logic [AW-1:0]     ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_addr;
    logic              wr_final;

    assign busy       = (state != S_RUN);
    assign load_ready = (state == S_LOAD);

    // CLEAR and LOAD share one write port driven by the sequencer pointer.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (state)
            S_CLEAR: wr_en = 1'b1;
            S_LOAD: begin
                wr_en   = load_valid;
                wr_data = load_data;
            end
            default: ;
        endcase
    end

    assign wr_final = load_last || (ptr == LAST_IDX);

    // The array has no reset: only the CLEAR pass zeroes it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= wr_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic par_mismatch;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_par[ptr] <= ^wr_data;
        end
    end

    assign par_mismatch = (^rd_word) != mem_par[rd_idx];
`endif

    assign misaligned = fetch_addr[0];
    assign rd_idx     = fetch_addr[AW:1];
    assign rd_word    = mem[rd_idx];

    generate
        if (ADDR_W - 1 > AW) begin : g_range_chk
            assign out_of_range = |fetch_addr[ADDR_W-1:AW+1];
        end else begin : g_no_range_chk
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign bad_addr = misaligned | out_of_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_CLEAR;
            ptr         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
`ifdef IMEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            case (state)
                S_CLEAR: begin
                    instr_valid <= 1'b0;
                    fault       <= 1'b0;
`ifdef IMEM_PARITY_EN
                    parity_err  <= 1'b0;
`endif
                    if (ptr == LAST_IDX) begin
                        state <= S_LOAD;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end

                S_LOAD: begin
                    instr_valid <= 1'b0;
                    fault       <= 1'b0;
`ifdef IMEM_PARITY_EN
                    parity_err  <= 1'b0;
`endif
                    // Pointer saturates at the last word; that word ends the burst.
                    if (load_valid) begin
                        if (wr_final) begin
                            state <= S_RUN;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end

                S_RUN: begin
                    if (load_start) begin
                        state       <= S_LOAD;
                        ptr         <= '0;
                        instr_valid <= 1'b0;
                        fault       <= 1'b0;
`ifdef IMEM_PARITY_EN
                        parity_err  <= 1'b0;
`endif
                    end else if (!stall) begin
                        if (fetch_en) begin
                            instr_valid <= 1'b1;
                            fault       <= bad_addr;
                            instr       <= bad_addr ? '0 : rd_word;
`ifdef IMEM_PARITY_EN
                            parity_err  <= !bad_addr && par_mismatch;
`endif
                        end else begin
                            instr_valid <= 1'b0;
                            fault       <= 1'b0;
`ifdef IMEM_PARITY_EN
                            parity_err  <= 1'b0;
`endif
                        end
                    end
                end

                default: begin
                    state <= S_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
